// File: rtl/chan_array_sequencer.sv
// Array of NUM_CH countdown channels launched serially or in parallel by a small controller FSM.
// Optional abort input is enabled with the SEQ_ABORT_EN macro.
module chan_array_sequencer #(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 8,
  parameter bit PARALLEL = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
`ifdef SEQ_ABORT_EN
  input  logic                                   abort_i,
`endif
  input  logic [NUM_CH*CNT_W-1:0]                load_val_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [NUM_CH-1:0]                      ch_active_o,
  output logic [NUM_CH-1:0]                      ch_done_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch_o
);

  localparam int CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t                      state_r;
  logic                        busy_r;
  logic                        done_r;
  logic [CUR_W-1:0]            cur_r;
  logic [CUR_W-1:0]            cur_nxt_s;
  logic [NUM_CH*CNT_W-1:0]     load_r;
  logic [NUM_CH-1:0]           active_s;
  logic [NUM_CH-1:0]           ch_done_s;
  logic [NUM_CH-1:0]           completing_s;
  logic [NUM_CH-1:0]           launch_s;
  logic                        accept_s;
  logic                        abort_s;
  logic                        kill_s;
  logic                        all_done_s;

`ifdef SEQ_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  assign accept_s   = (state_r == IDLE) && start_i;
  assign kill_s     = abort_s && (state_r != IDLE);
  // The run ends on the edge where every channel is either done already or finishing now.
  assign all_done_s = &(ch_done_s | completing_s);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] value_s;
    logic             act_r;
    logic             fin_r;

    // Channel 0 (and every channel in parallel mode) loads on the accept edge, before load_r is valid.
    assign value_s         = accept_s ? load_val_i[k*CNT_W +: CNT_W] : load_r[k*CNT_W +: CNT_W];
    assign completing_s[k] = act_r && (cnt_r == {CNT_W{1'b0}});
    assign active_s[k]     = act_r;
    assign ch_done_s[k]    = fin_r;

    if (k == 0) begin : g_first
      assign launch_s[k] = accept_s;
    end else if (PARALLEL) begin : g_par
      assign launch_s[k] = accept_s;
    end else begin : g_ser
      assign launch_s[k] = completing_s[k-1];
    end

    // Countdown unit: load on launch, decrement while active, complete at zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        act_r <= 1'b0;
        cnt_r <= {CNT_W{1'b0}};
        fin_r <= 1'b0;
      end else if (kill_s) begin
        act_r <= 1'b0;
        cnt_r <= {CNT_W{1'b0}};
        fin_r <= fin_r;
      end else begin
        if (accept_s) begin
          fin_r <= 1'b0;
        end else if (completing_s[k]) begin
          fin_r <= 1'b1;
        end else begin
          fin_r <= fin_r;
        end
        if (launch_s[k]) begin
          act_r <= 1'b1;
          cnt_r <= value_s;
        end else if (completing_s[k]) begin
          act_r <= 1'b0;
          cnt_r <= cnt_r;
        end else if (act_r) begin
          act_r <= act_r;
          cnt_r <= cnt_r - CNT_W'(1);
        end else begin
          act_r <= act_r;
          cnt_r <= cnt_r;
        end
      end
    end
  end

  // Serial mode: the channel following the one finishing now becomes the current one.
  always_comb begin
    cur_nxt_s = cur_r;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      if (completing_s[k]) begin
        cur_nxt_s = CUR_W'(k + 1);
      end else begin
        cur_nxt_s = cur_nxt_s;
      end
    end
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cur_r   <= {CUR_W{1'b0}};
      load_r  <= {(NUM_CH*CNT_W){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          cur_r  <= {CUR_W{1'b0}};
          if (start_i) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            load_r  <= load_val_i;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            load_r  <= load_r;
          end
        end
        RUN: begin
          if (kill_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cur_r   <= {CUR_W{1'b0}};
          end else if (all_done_s) begin
            state_r <= FIN;
            busy_r  <= 1'b1;
            done_r  <= 1'b1;
            cur_r   <= PARALLEL ? {CUR_W{1'b0}} : cur_nxt_s;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cur_r   <= PARALLEL ? {CUR_W{1'b0}} : cur_nxt_s;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cur_r   <= {CUR_W{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cur_r   <= {CUR_W{1'b0}};
        end
      endcase
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign ch_active_o = active_s;
  assign ch_done_o   = ch_done_s;
  assign cur_ch_o    = cur_r;

endmodule

// File: tb/tb_chan_array_sequencer.sv
// Bench for chan_array_sequencer: a serial and a parallel instance checked cycle by cycle
// against interval-based expectations derived from the channel load values.
module tb_chan_array_sequencer;
  localparam int N = 5;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_ser;
  logic             start_par;
  logic             abort;
  logic [N*W-1:0]   load_val;

  logic             busy_ser, done_ser, busy_par, done_par;
  logic [N-1:0]     act_ser, fin_ser, act_par, fin_par;
  logic [2:0]       cur_ser, cur_par;

  int checks = 0;
  int errors = 0;
  int v[N];

  always #5 clk = ~clk;

  chan_array_sequencer #(.NUM_CH(N), .CNT_W(W), .PARALLEL(1'b0)) dut_ser (
    .clk(clk), .rst(rst), .start_i(start_ser),
`ifdef SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .load_val_i(load_val), .busy_o(busy_ser), .done_o(done_ser),
    .ch_active_o(act_ser), .ch_done_o(fin_ser), .cur_ch_o(cur_ser)
  );

  chan_array_sequencer #(.NUM_CH(N), .CNT_W(W), .PARALLEL(1'b1)) dut_par (
    .clk(clk), .rst(rst), .start_i(start_par),
`ifdef SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .load_val_i(load_val), .busy_o(busy_par), .done_o(done_par),
    .ch_active_o(act_par), .ch_done_o(fin_par), .cur_ch_o(cur_par)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: start at edge 0, observe cycles 1..R+3. restart_at re-pulses start with new values,
  // kill_at asserts rst (or abort) during that RUN cycle.
  task automatic run(input bit par, input int restart_at, input int kill_at, input bit is_abort);
    int st[N];
    int en[N];
    int s;
    int r;
    logic [N-1:0] e_act;
    logic [N-1:0] e_fin;
    int e_cur;
    bit e_busy;
    bit e_done;
    s = 1;
    r = 0;
    for (int k = 0; k < N; k++) begin
      if (par) begin
        st[k] = 1;
        en[k] = 1 + v[k];
      end else begin
        st[k] = s;
        en[k] = s + v[k];
        s = en[k] + 1;
      end
      if (en[k] > r) r = en[k];
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) load_val[k*W +: W] = W'(v[k]);
    if (par) start_par = 1'b1; else start_ser = 1'b1;
    for (int t = 1; t <= r + 3; t++) begin
      @(negedge clk);
      start_ser = 1'b0;
      start_par = 1'b0;
      rst       = 1'b0;
      abort     = 1'b0;
      e_busy = (t <= r + 1);
      e_done = (t == r + 1);
      e_cur  = 0;
      for (int k = 0; k < N; k++) begin
        e_act[k] = (t >= st[k]) && (t <= en[k]);
        e_fin[k] = (t > en[k]);
        if (!par && e_act[k]) e_cur = k;
      end
      if (kill_at > 0 && t > kill_at) begin
        e_busy = 1'b0;
        e_done = 1'b0;
        e_act  = '0;
        for (int k = 0; k < N; k++) e_fin[k] = is_abort && (en[k] < kill_at);
      end
      if (par) begin
        chk("busy_par", 64'(busy_par), 64'(e_busy));
        chk("done_par", 64'(done_par), 64'(e_done));
        chk("act_par",  64'(act_par),  64'(e_act));
        chk("fin_par",  64'(fin_par),  64'(e_fin));
        if (e_busy) chk("cur_par", 64'(cur_par), 64'd0);
      end else begin
        chk("busy_ser", 64'(busy_ser), 64'(e_busy));
        chk("done_ser", 64'(done_ser), 64'(e_done));
        chk("act_ser",  64'(act_ser),  64'(e_act));
        chk("fin_ser",  64'(fin_ser),  64'(e_fin));
        if (e_busy && t <= r) chk("cur_ser", 64'(cur_ser), 64'(e_cur));
      end
      if (t == restart_at) begin
        load_val = (N*W)'({$urandom, $urandom});
        if (par) start_par = 1'b1; else start_ser = 1'b1;
      end
      if (t == kill_at) begin
        if (is_abort) abort = 1'b1; else rst = 1'b1;
      end
    end
  endtask

  task automatic rand_v();
    for (int k = 0; k < N; k++) v[k] = $urandom_range(6, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start_ser = 1'b0;
    start_par = 1'b0;
    abort     = 1'b0;
    load_val  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy_ser", 64'(busy_ser), 64'd0);
    chk("rst_done_ser", 64'(done_ser), 64'd0);
    chk("rst_act_ser",  64'(act_ser),  64'd0);
    chk("rst_fin_ser",  64'(fin_ser),  64'd0);
    chk("rst_cur_ser",  64'(cur_ser),  64'd0);
    chk("rst_busy_par", 64'(busy_par), 64'd0);
    chk("rst_act_par",  64'(act_par),  64'd0);
    chk("rst_fin_par",  64'(fin_par),  64'd0);
    rst = 1'b0;

    v = '{2, 0, 1, 3, 0};
    run(1'b0, 0, 0, 1'b0);
    v = '{4, 1, 7, 0, 2};
    run(1'b1, 0, 0, 1'b0);
    v = '{2, 0, 1, 3, 0};
    run(1'b0, 4, 0, 1'b0);
    v = '{4, 1, 7, 0, 2};
    run(1'b1, 3, 0, 1'b0);
    v = '{2, 0, 1, 3, 0};
    run(1'b0, 0, 3, 1'b0);
    v = '{0, 0, 0, 0, 0};
    run(1'b0, 0, 0, 1'b0);
    run(1'b1, 0, 0, 1'b0);
    v = '{2, 0, 1, 3, 0};
    run(1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rand_v();
      run(1'b0, 0, 0, 1'b0);
      rand_v();
      run(1'b1, 0, 0, 1'b0);
    end
    rand_v();
    run(1'b1, 0, 1, 1'b0);
    rand_v();
    run(1'b0, 2, 0, 1'b0);

`ifdef SEQ_ABORT_EN
    v = '{3, 3, 3, 3, 3};
    run(1'b0, 0, 6, 1'b1);
    rand_v();
    run(1'b0, 0, 0, 1'b0);
    v = '{3, 3, 3, 3, 3};
    run(1'b1, 0, 2, 1'b1);
    rand_v();
    run(1'b1, 0, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chan_array_sequencer.md
Name: chan_array_sequencer

Overview:
- Parametrised successor to the fixed five-instance structural root module.
- Generates NUM_CH countdown channel units with a generate loop and adds a controller FSM that launches them serially or in parallel.
- Provides a start/busy/done handshake to the parent level.
- Sits one level below the root of a module tree. Replaces hard-coded child instantiation with a depth-scalable array.

Parameters:
- NUM_CH, 5, number of channel units generated (1..64).
- CNT_W, 8, width of each channel's countdown counter and load value.
- PARALLEL, 0, 0 = channels run one after another in index order; 1 = all channels launch together.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle request to begin a run; sampled only in IDLE.
- load_val_i  input  NUM_CH*CNT_W  per-channel countdown values; channel k uses bits [k*CNT_W +: CNT_W]; captured on accepted start.
- busy_o  output  1  high from the cycle after an accepted start until done_o has pulsed.
- done_o  output  1  one-cycle pulse when all channels have completed.
- ch_active_o  output  NUM_CH  per-channel counting flag.
- ch_done_o  output  NUM_CH  sticky per-channel completion; cleared on accepted start or rst.
- cur_ch_o  output  max(1,$clog2(NUM_CH))  index of the active channel in serial mode; 0 in parallel mode.

Behaviour:
- Reset: clk and rst are the only clock and reset.
  - Synchronous, active-high rst forces FSM to IDLE, all counters to 0, and all outputs to 0.
  - rst mid-run aborts immediately; no done_o is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN when start_i=1. That edge latches load_val_i and clears ch_done_o.
  - RUN→FIN on the cycle the last channel completes.
  - FIN→IDLE unconditionally. done_o=1 only while in FIN.
- busy_o = (state != IDLE).
- start_i in RUN or FIN is ignored; it is not queued.
- Channel counting:
  - On activation, a channel loads its latched value V.
  - Each active cycle: if count==0, the channel completes, clears its active flag and sets its ch_done bit; otherwise it decrements.
  - A channel is therefore active for V+1 cycles; V=0 gives one active cycle.
  - No wrap-around: the counter never decrements below 0.
- Serial mode (PARALLEL=0):
  - Channel 0 activates on the first RUN cycle.
  - Channel k+1 activates in the cycle immediately after channel k completes (no gap cycle). cur_ch_o tracks the active channel.
  - Total RUN cycles = sum over k of (V_k+1). done_o rises in the cycle after the last completion.
- Parallel mode (PARALLEL=1):
  - All channels activate on the first RUN cycle and complete independently.
  - RUN lasts max(V_k)+1 cycles.
- NUM_CH=1: cur_ch_o is 1 bit and held at 0.
- Start→done latency: accepted start at edge 0 → done_o high during cycle (RUN cycles + 1).

Optional Feature:
- Macro SEQ_ABORT_EN.
- When defined:
  - Adds input port abort_i (1 bit).
  - abort_i=1 in RUN or FIN returns the FSM to IDLE at the next edge, clears ch_active_o and all counters, and suppresses done_o.
  - ch_done_o keeps the bits of channels that already completed.
  - abort_i in IDLE has no effect.
  - abort_i and start_i together in IDLE: start wins.
- When undefined: no abort_i port. A run can only be terminated by rst.

Test Plan:
- Serial, NUM_CH=5, V={2,0,1,3,0}, pulse start_i → busy_o for 12 cycles (RUN 11 cycles + FIN), then done_o pulses once; ch_done_o=5'b11111; cur_ch_o steps 0,0,0,1,2,2,3,3,3,3,4.
- Parallel, NUM_CH=5, V={4,1,7,0,2}, start → all ch_active_o high on first RUN cycle; ch_done bit 3 sets after 1 cycle and bit 2 after 8; done_o in cycle 9.
- Start ignored: pulse start_i again during RUN with new values → no restart; original timing kept; only one done_o.
- rst asserted on 3rd RUN cycle of the first scenario → next cycle busy_o=0, ch_active_o=0, ch_done_o=0; no done_o ever appears.
- All V=0, serial, NUM_CH=5 → RUN 5 cycles, done_o in cycle 6; same stimulus in parallel → done_o in cycle 2.
- SEQ_ABORT_EN, serial, V={3,3,3,3,3}, abort_i on RUN cycle 6 → IDLE next edge; ch_done_o=5'b00001; no done_o; a following start runs normally.
